psk_symbol_mixer: RTL and testbench
===================================

// Module: psk_symbol_mixer
// PURPOSE
//  Next-generation TX mixer: maps a stream of data symbols onto the carrier in BPSK or QPSK mode.
//  Holds each symbol for SPS carrier samples, handshakes symbols in from the framer,
//  and emits signed samples to the DAC path. Handles underrun and saturates negation.
//  Sits between the carrier NCO (sine/cosine) and the DAC interface.
// PARAMETERS
//  W    8   carrier/output sample width, signed two's complement (W >= 4)
//  SPS  16  carrier samples per symbol (2..65535); counter width = $clog2(SPS)
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst         in   1  synchronous reset, active-high
//  mod_ena     in   1  modulator enable; low forces IDLE
//  mode        in   1  0 = BPSK (uses sym_data[0]), 1 = QPSK (sym_data[1]=I, [0]=Q)
//  sym_data    in   2  symbol bits, sampled when sym_valid && sym_ready
//  sym_valid   in   1  framer has a symbol
//  sym_ready   out  1  mixer accepts a symbol this cycle
//  sine        in   W  signed carrier, quadrature (Q) branch
//  cosine      in   W  signed carrier, in-phase (I) branch
//  car_stb     in   1  sine/cosine hold a new valid sample this cycle
//  ena_mod     out  1  high while the mixer is in RUN
//  out_valid   out  1  mod_out updated this cycle (one pulse per car_stb in RUN)
//  mod_out     out  W  signed modulated sample
//  underrun    out  1  sticky: symbol boundary reached with no symbol available
// BEHAVIOUR
//  Reset: state=IDLE; sym_ready=0, ena_mod=0, out_valid=0, mod_out=0, underrun=0, counter=0.
//  States: IDLE, RUN, STARVE.
//   IDLE:   sym_ready = mod_ena. On accept (valid&&ready): latch symbol and mode, counter=0, go RUN.
//   RUN:    on each car_stb: emit sample, counter++. When car_stb with counter==SPS-1:
//           counter=0; if sym_valid, accept the next symbol that same cycle (sym_ready=1 only
//           in that cycle) and stay in RUN, else set underrun=1 and go STARVE.
//   STARVE: mod_out=0; out_valid pulses on car_stb (zero samples keep DAC timing);
//           sym_ready=1; on accept latch the symbol and go RUN with counter=0. underrun stays 1.
//  underrun clears only on rst, or on a mod_ena 0->1 transition.
//  mod_ena low in any state: next cycle state=IDLE, mod_out=0, out_valid=0, ena_mod=0,
//   sym_ready=0; the held symbol is discarded. No partial symbol resumes.
//  mode is latched per symbol at accept; mode changes mid-symbol have no effect until next accept.
//  Sample math (registered, latency 1 cycle from car_stb to out_valid/mod_out):
//   neg(x) = -x, saturated: neg(-2^(W-1)) = 2^(W-1)-1.
//   BPSK: mod_out = b0 ? sine : neg(sine).
//   QPSK: s = (I ? cosine : neg(cosine)) + (Q ? sine : neg(sine)) in W+1 bits;
//         mod_out = s >>> 1 (arithmetic shift, truncates toward -inf); always fits W bits.
//  Between car_stb pulses mod_out holds its last value; out_valid=0.
//  Simultaneous rst and any input: rst wins. Simultaneous last-sample strobe and mod_ena
//   fall: mod_ena wins (IDLE, no accept, no underrun).
//  ena_mod = (state==RUN), registered.
// TESTING
//  T1 BPSK W=8 SPS=4, symbols 1,0 back-to-back, sine=+50 every cycle ->
//     mod_out +50 x4 then -50 x4, out_valid 8 pulses, one cycle after each car_stb.
//  T2 BPSK data=0, sine=-128 -> mod_out=+127 (saturation), never -128 or 0.
//  T3 QPSK I=1,Q=0, cosine=100, sine=40 -> mod_out=(100-40)>>>1=30; I=0,Q=0, cos=-128, sin=-128 -> 127.
//  T4 SPS=4, one symbol then sym_valid=0 -> underrun=1 after 4th sample, 0x00 samples follow;
//     new symbol accepted -> RUN, underrun stays 1 until mod_ena toggles.
//  T5 mod_ena drops at sample 2 of 4 -> next cycle ena_mod=0, mod_out=0, sym_ready=0;
//     re-enable -> fresh accept, counter restarts at 0.
//  T6 rst asserted mid-RUN with car_stb=1 -> all outputs at reset values next cycle, no out_valid.

Source files
------------

// File: rtl/psk_symbol_mixer.sv
// psk_symbol_mixer
// BPSK/QPSK transmit mixer. Takes symbols from the framer via a valid/ready
// handshake, holds each one for SPS carrier strobes, and multiplies the NCO
// carrier by +/-1 per branch. Negation saturates so that -(-2^(W-1)) can't
// wrap. QPSK sums both branches in W+1 bits and halves the result, which
// always fits back into W bits.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no symbol held; ready follows mod_ena, output frozen
// RUN    | symbol held; one modulated sample per carrier strobe
// STARVE | symbol ran out with nothing queued; zero samples keep DAC timing

module psk_symbol_mixer #(
    parameter int W   = 8,
    parameter int SPS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mod_ena,
    input  logic                mode,
    input  logic [1:0]          sym_data,
    input  logic                sym_valid,
    output logic                sym_ready,
    input  logic signed [W-1:0] sine,
    input  logic signed [W-1:0] cosine,
    input  logic                car_stb,
    output logic                ena_mod,
    output logic                out_valid,
    output logic signed [W-1:0] mod_out,
    output logic                underrun
);

    localparam int                  CW    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0]       LAST  = CW'(SPS - 1);
    localparam logic signed [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        STARVE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Symbol held for the current SPS-sample window, with the mode it was sent in.
    logic sym_i;
    logic sym_q;
    logic sym_mode;

    logic mod_ena_q;

    logic ready_c;
    logic accept;
    logic emit;
    logic emit_zero;
    logic flush;
    logic set_underrun;

    logic signed [W-1:0] i_term;
    logic signed [W-1:0] q_term;
    logic signed [W:0]   qpsk_sum;
    logic signed [W-1:0] sample;

    // Two's-complement negate that pins the most negative code at full scale.
    function automatic logic signed [W-1:0] sat_neg(input logic signed [W-1:0] x);
        if (x == S_MIN) begin
            return S_MAX;
        end
        return -x;
    endfunction

    // Ready is qualified by rst so nothing looks accepted while reset is held.
    assign sym_ready = ready_c & ~rst;
    assign accept    = sym_ready & sym_valid;

    // State register and per-symbol sample counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, handshake and sample-strobe decode; mod_ena low overrides everything.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        ready_c      = 1'b0;
        emit         = 1'b0;
        emit_zero    = 1'b0;
        flush        = 1'b0;
        set_underrun = 1'b0;

        if (!mod_ena) begin
            state_next = IDLE;
            cnt_next   = '0;
            flush      = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    ready_c = 1'b1;
                    if (sym_valid) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end
                end
                RUN: begin
                    if (car_stb) begin
                        emit = 1'b1;
                        if (cnt == LAST) begin
                            cnt_next = '0;
                            ready_c  = 1'b1;
                            if (!sym_valid) begin
                                set_underrun = 1'b1;
                                state_next   = STARVE;
                            end
                        end else begin
                            cnt_next = cnt + CW'(1);
                        end
                    end
                end
                STARVE: begin
                    ready_c   = 1'b1;
                    emit_zero = car_stb;
                    if (sym_valid) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Carrier times the held symbol; QPSK halves the branch sum to stay in W bits.
    always_comb begin
        i_term   = sym_i ? cosine : sat_neg(cosine);
        q_term   = sym_q ? sine : sat_neg(sine);
        qpsk_sum = {i_term[W-1], i_term} + {q_term[W-1], q_term};
        if (sym_mode) begin
            sample = qpsk_sum[W:1];
        end else begin
            sample = q_term;
        end
    end

    // Symbol latch at each accept; the sample in flight still uses the old symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            sym_i    <= 1'b0;
            sym_q    <= 1'b0;
            sym_mode <= 1'b0;
        end else if (accept) begin
            sym_i    <= sym_data[1];
            sym_q    <= sym_data[0];
            sym_mode <= mode;
        end
    end

    // Registered sample output: one cycle after each strobe, held in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            mod_out   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            mod_out   <= '0;
        end else if (emit) begin
            out_valid <= 1'b1;
            mod_out   <= sample;
        end else if (emit_zero) begin
            out_valid <= 1'b1;
            mod_out   <= '0;
        end else begin
            out_valid <= 1'b0;
        end
    end

    // Status flags: RUN indicator, and sticky underrun cleared by re-enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ena_mod   <= 1'b0;
            underrun  <= 1'b0;
            mod_ena_q <= 1'b0;
        end else begin
            ena_mod   <= (state_next == RUN);
            mod_ena_q <= mod_ena;
            if (mod_ena && !mod_ena_q) begin
                underrun <= 1'b0;
            end else if (set_underrun) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psk_symbol_mixer.sv
// Testbench for psk_symbol_mixer (W=8, SPS=4): sample-math table, hand
// sequences for underrun / disable / reset, then random traffic against a
// behavioural model that tracks samples-left-in-symbol.

module tb_psk_symbol_mixer;

    localparam int W   = 8;
    localparam int SPS = 4;

    logic                clk;
    logic                rst;
    logic                mod_ena;
    logic                mode;
    logic [1:0]          sym_data;
    logic                sym_valid;
    logic                sym_ready;
    logic signed [W-1:0] sine;
    logic signed [W-1:0] cosine;
    logic                car_stb;
    logic                ena_mod;
    logic                out_valid;
    logic signed [W-1:0] mod_out;
    logic                underrun;

    psk_symbol_mixer #(.W(W), .SPS(SPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .mod_ena   (mod_ena),
        .mode      (mode),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sine      (sine),
        .cosine    (cosine),
        .car_stb   (car_stb),
        .ena_mod   (ena_mod),
        .out_valid (out_valid),
        .mod_out   (mod_out),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    bit       m_active  = 0;
    bit       m_starved = 0;
    int       m_left    = 0;
    bit [1:0] m_bits    = 0;
    bit       m_mode    = 0;
    bit       m_und     = 0;
    bit       m_prev    = 0;
    bit       m_valid   = 0;
    bit       m_ena     = 0;
    int       m_out     = 0;

    typedef struct {
        bit       mode;
        bit [1:0] data;
        int       sn;
        int       cs;
        int       exp;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int neg_sat(input int x);
        if (x == -(2 ** (W - 1))) return 2 ** (W - 1) - 1;
        return -x;
    endfunction

    function automatic int floor_half(input int x);
        if (x >= 0) return x / 2;
        return -((-x + 1) / 2);
    endfunction

    function automatic int ref_sample(input bit m, input bit [1:0] b, input int s, input int c);
        int ip;
        int qp;
        qp = b[0] ? s : neg_sat(s);
        if (!m) return qp;
        ip = b[1] ? c : neg_sat(c);
        return floor_half(ip + qp);
    endfunction

    function automatic bit model_ready();
        if (rst || !mod_ena) return 1'b0;
        if (!m_active) return 1'b1;
        return car_stb && (m_left == 1);
    endfunction

    task automatic take_symbol();
        m_active = 1;
        m_left   = SPS;
        m_bits   = sym_data;
        m_mode   = mode;
    endtask

    task automatic model_clock();
        if (rst) begin
            m_active = 0; m_starved = 0; m_left = 0; m_und = 0;
            m_prev = 0; m_valid = 0; m_out = 0;
        end else if (!mod_ena) begin
            m_active = 0; m_starved = 0; m_valid = 0; m_out = 0; m_prev = 0;
        end else begin
            if (!m_prev) m_und = 0;
            m_prev  = 1;
            m_valid = 0;
            if (m_active) begin
                if (car_stb) begin
                    m_valid = 1;
                    m_out   = ref_sample(m_mode, m_bits, int'(sine), int'(cosine));
                    m_left--;
                    if (m_left == 0) begin
                        if (sym_valid) begin
                            take_symbol();
                        end else begin
                            m_active = 0; m_starved = 1; m_und = 1;
                        end
                    end
                end
            end else begin
                if (m_starved && car_stb) begin
                    m_valid = 1;
                    m_out   = 0;
                end
                if (sym_valid) begin
                    take_symbol();
                    m_starved = 0;
                end
            end
        end
        m_ena = m_active;
    endtask

    // One clock: drive inputs, check ready before the edge, outputs after it.
    task automatic apply(input bit r, input bit e, input bit m, input bit [1:0] d,
                         input bit v, input bit s, input int sn, input int cs);
        rst = r; mod_ena = e; mode = m; sym_data = d; sym_valid = v; car_stb = s;
        sine = 8'(sn); cosine = 8'(cs);
        #1;
        chk("sym_ready", int'(sym_ready), int'(model_ready()));
        @(posedge clk);
        #1;
        model_clock();
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("mod_out", int'(mod_out), m_out);
        chk("ena_mod", int'(ena_mod), int'(m_ena));
        chk("underrun", int'(underrun), int'(m_und));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ena_r;
        int sn;
        int cs;

        tbl[0]  = '{0, 2'b01,   50,    0,   50};
        tbl[1]  = '{0, 2'b00,   50,    0,  -50};
        tbl[2]  = '{0, 2'b00, -128,    0,  127};
        tbl[3]  = '{0, 2'b01, -128,    0, -128};
        tbl[4]  = '{0, 2'b00,  127,    0, -127};
        tbl[5]  = '{1, 2'b10,   40,  100,   30};
        tbl[6]  = '{1, 2'b00, -128, -128,  127};
        tbl[7]  = '{1, 2'b11,  127,  127,  127};
        tbl[8]  = '{1, 2'b11, -128, -128, -128};
        tbl[9]  = '{1, 2'b01,    0,    3,   -2};
        tbl[10] = '{0, 2'b10,   10,   99,  -10};
        tbl[11] = '{1, 2'b01,   20,   10,    5};

        // Reset state
        apply(1, 0, 0, 2'b00, 0, 0, 0, 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_out", int'(mod_out), 0);
        chk("rst_ena", int'(ena_mod), 0);
        chk("rst_und", int'(underrun), 0);

        // T1 + T4: symbols 1 then 0, then starve
        apply(0, 1, 0, 2'b01, 1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            apply(0, 1, 0, 2'b00, (k < 4), 1, 50, 0);
            chk("t1_valid", int'(out_valid), 1);
            chk("t1_out", int'(mod_out), (k < 4) ? 50 : -50);
        end
        chk("t4_und_set", int'(underrun), 1);
        for (int k = 0; k < 2; k++) begin
            apply(0, 1, 0, 2'b00, 0, 1, 77, 0);
            chk("t4_zero", int'(mod_out), 0);
            chk("t4_zvalid", int'(out_valid), 1);
        end
        apply(0, 1, 0, 2'b01, 1, 0, 0, 0);
        chk("t4_rerun", int'(ena_mod), 1);
        chk("t4_und_sticky", int'(underrun), 1);

        // T5: drop enable mid-symbol, re-enable, counter restarts
        apply(0, 1, 0, 2'b00, 0, 1, 50, 0);
        apply(0, 0, 0, 2'b00, 1, 1, 50, 0);
        chk("t5_ena", int'(ena_mod), 0);
        chk("t5_out", int'(mod_out), 0);
        chk("t5_valid", int'(out_valid), 0);
        apply(0, 1, 0, 2'b01, 1, 0, 0, 0);
        chk("t5_und_clr", int'(underrun), 0);
        for (int k = 0; k < 4; k++) begin
            apply(0, 1, 0, 2'b00, 0, 1, 60, 0);
            chk("t5_und_cnt", int'(underrun), (k == 3) ? 1 : 0);
        end

        // T6: reset mid-RUN with a strobe
        apply(0, 1, 0, 2'b01, 1, 0, 0, 0);
        apply(0, 1, 0, 2'b00, 0, 1, 33, 0);
        apply(1, 1, 0, 2'b01, 1, 1, 33, 0);
        chk("t6_valid", int'(out_valid), 0);
        chk("t6_out", int'(mod_out), 0);
        chk("t6_ena", int'(ena_mod), 0);
        chk("t6_und", int'(underrun), 0);

        // Last strobe coincident with enable fall: no accept, no underrun
        apply(0, 1, 0, 2'b01, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) apply(0, 1, 0, 2'b00, 0, 1, 20, 0);
        apply(0, 0, 0, 2'b00, 0, 1, 20, 0);
        chk("fall_und", int'(underrun), 0);
        chk("fall_ena", int'(ena_mod), 0);

        // Sample-math table; mode/data flipped after accept to prove latching
        for (int i = 0; i < 12; i++) begin
            apply(0, 0, 0, 2'b00, 0, 0, 0, 0);
            apply(0, 1, tbl[i].mode, tbl[i].data, 1, 0, 0, 0);
            apply(0, 1, !tbl[i].mode, ~tbl[i].data, 0, 1, tbl[i].sn, tbl[i].cs);
            chk("tbl_out", int'(mod_out), tbl[i].exp);
            chk("tbl_valid", int'(out_valid), 1);
        end

        // Random traffic against the model
        ena_r = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) ena_r = !ena_r;
            sn = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
            cs = ($urandom_range(0, 7) == 0) ? -128 : int'($urandom_range(0, 255)) - 128;
            apply(($urandom_range(0, 299) == 0), ena_r, 1'($urandom), 2'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), sn, cs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
